// File: rtl/riscv_ctrl_pkg.sv
//==============================================================================
// riscv_ctrl_pkg: shared encodings and state type for the RV32I multi-cycle control path
// Revision: 1.0
//==============================================================================
`default_nettype none

package riscv_ctrl_pkg;

    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    localparam logic [1:0] c_aluop_add = 2'b00;
    localparam logic [1:0] c_aluop_sub = 2'b01;
    localparam logic [1:0] c_aluop_r   = 2'b10;
    localparam logic [1:0] c_aluop_i   = 2'b11;

    localparam logic [2:0] c_imm_i = 3'b000;
    localparam logic [2:0] c_imm_s = 3'b001;
    localparam logic [2:0] c_imm_b = 3'b010;
    localparam logic [2:0] c_imm_j = 3'b011;
    localparam logic [2:0] c_imm_u = 3'b100;

    localparam logic [1:0] c_res_aluout    = 2'b00;
    localparam logic [1:0] c_res_memdata   = 2'b01;
    localparam logic [1:0] c_res_aluresult = 2'b10;

    localparam logic [1:0] c_srca_pc    = 2'b00;
    localparam logic [1:0] c_srca_oldpc = 2'b01;
    localparam logic [1:0] c_srca_rs1   = 2'b10;
    localparam logic [1:0] c_srca_zero  = 2'b11;

    localparam logic [1:0] c_srcb_rs2  = 2'b00;
    localparam logic [1:0] c_srcb_imm  = 2'b01;
    localparam logic [1:0] c_srcb_four = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_EXEC_I  = 4'd7,
        S_LUI     = 4'd8,
        S_ALU_WB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JAL     = 4'd11,
        S_JALR    = 4'd12,
        S_JALR_PC = 4'd13,
        S_ILLEGAL = 4'd14
    } state_t;

    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            c_op_load, c_op_imm, c_op_jalr: imm_src_of = c_imm_i;
            c_op_store:                     imm_src_of = c_imm_s;
            c_op_branch:                    imm_src_of = c_imm_b;
            c_op_jal:                       imm_src_of = c_imm_j;
            c_op_lui:                       imm_src_of = c_imm_u;
            default:                        imm_src_of = c_imm_i;
        endcase
    endfunction

    // Only beq/bne/blt/bge are implemented; other branch funct3 values trap.
    function automatic logic branch_f3_legal(input logic [2:0] func3);
        branch_f3_legal = (func3 == 3'b000) || (func3 == 3'b001) ||
                          (func3 == 3'b100) || (func3 == 3'b101);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_if.sv
//==============================================================================
// multicycle_controller_if: decode inputs, memory handshake and datapath controls
// Revision: 1.0
//==============================================================================
`default_nettype none

interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] func3;
    logic       zero;
    logic       neg;
    logic       mem_ready;
    logic       mem_req;
    logic       MemWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       PCWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ImmSrc;
    logic [1:0] ALUOp;
    logic       retire;
    logic       trap;

    modport master (
        input  op, func3, zero, neg, mem_ready,
        output mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, retire, trap
    );

    modport slave (
        output op, func3, zero, neg, mem_ready,
        input  mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUOp, retire, trap
    );
endinterface

`default_nettype wire

// File: rtl/multicycle_controller_branch_cond.sv
//==============================================================================
// branch_cond: branch-taken decision from funct3 and the ALU zero/neg flags
// Revision: 1.0
//==============================================================================
`default_nettype none

module branch_cond (
    input  wire logic [2:0] func3,
    input  wire logic       zero,
    input  wire logic       neg,
    output logic            taken
);
    always_comb begin
        taken = 1'b0;
        case (func3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = neg;
            3'b101:  taken = ~neg;
            default: taken = 1'b0;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
//==============================================================================
// multicycle_controller: fetch/decode/execute/memory/writeback sequencer for RV32I
// Revision: 1.0
//==============================================================================
`default_nettype none

module multicycle_controller
    import riscv_ctrl_pkg::*;
(
    input  wire logic               clk,
    input  wire logic               rst,
    multicycle_controller_if.master bus
);
    state_t     r_state;
    logic       w_taken;
    logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write;
    logic       w_reg_write, w_retire, w_trap;
    logic [1:0] w_result_src, w_src_a, w_src_b, w_alu_op;

    branch_cond u_branch_cond (
        .func3 (bus.func3),
        .zero  (bus.zero),
        .neg   (bus.neg),
        .taken (w_taken)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:   if (bus.mem_ready) r_state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        c_op_load, c_op_store: r_state <= S_MEM_ADR;
                        c_op_r:                r_state <= S_EXEC_R;
                        c_op_imm:              r_state <= S_EXEC_I;
                        c_op_branch:           r_state <= branch_f3_legal(bus.func3) ? S_BRANCH : S_ILLEGAL;
                        c_op_jal:              r_state <= S_JAL;
                        c_op_jalr:             r_state <= S_JALR;
                        c_op_lui:              r_state <= S_LUI;
                        default:               r_state <= S_ILLEGAL;
                    endcase
                end
                S_MEM_ADR: r_state <= (bus.op == c_op_load) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD:  if (bus.mem_ready) r_state <= S_MEM_WB;
                S_MEM_WR:  if (bus.mem_ready) r_state <= S_FETCH;
                S_EXEC_R, S_EXEC_I, S_LUI, S_JAL, S_JALR_PC: r_state <= S_ALU_WB;
                S_JALR:    r_state <= S_JALR_PC;
                S_ILLEGAL: r_state <= S_ILLEGAL;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_retire     = 1'b0;
        w_trap       = 1'b0;
        w_result_src = c_res_aluout;
        w_src_a      = c_srca_pc;
        w_src_b      = c_srcb_rs2;
        w_alu_op     = c_aluop_add;
        case (r_state)
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_src_b      = c_srcb_four;
                w_result_src = c_res_aluresult;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                w_src_a = c_srca_oldpc;
                w_src_b = c_srcb_imm;
            end
            S_MEM_ADR, S_JALR: begin
                w_src_a = c_srca_rs1;
                w_src_b = c_srcb_imm;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
            end
            S_MEM_WB: begin
                w_result_src = c_res_memdata;
                w_reg_write  = 1'b1;
                w_retire     = 1'b1;
            end
            S_MEM_WR: begin
                w_mem_req   = 1'b1;
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
                w_retire    = bus.mem_ready;
            end
            S_EXEC_R: begin
                w_src_a  = c_srca_rs1;
                w_alu_op = c_aluop_r;
            end
            S_EXEC_I: begin
                w_src_a  = c_srca_rs1;
                w_src_b  = c_srcb_imm;
                w_alu_op = c_aluop_i;
            end
            S_LUI: begin
                w_src_a = c_srca_zero;
                w_src_b = c_srcb_imm;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_retire    = 1'b1;
            end
            S_BRANCH: begin
                w_src_a    = c_srca_rs1;
                w_alu_op   = c_aluop_sub;
                w_pc_write = w_taken;
                w_retire   = 1'b1;
            end
            // Link value OldPC+4 goes to ALUResult while ALUOut (target) loads the PC.
            S_JAL, S_JALR_PC: begin
                w_src_a    = c_srca_oldpc;
                w_src_b    = c_srcb_four;
                w_pc_write = 1'b1;
            end
            S_ILLEGAL: w_trap = 1'b1;
            default: ;
        endcase
    end

    // Enables are masked by reset so an abandoned access cannot write anything.
    assign bus.mem_req   = rst & w_mem_req;
    assign bus.MemWrite  = rst & w_mem_write;
    assign bus.AdrSrc    = w_adr_src;
    assign bus.IRWrite   = rst & w_ir_write;
    assign bus.PCWrite   = rst & w_pc_write;
    assign bus.RegWrite  = rst & w_reg_write;
    assign bus.retire    = rst & w_retire;
    assign bus.trap      = rst & w_trap;
    assign bus.ResultSrc = w_result_src;
    assign bus.ALUSrcA   = w_src_a;
    assign bus.ALUSrcB   = w_src_b;
    assign bus.ALUOp     = w_alu_op;
    assign bus.ImmSrc    = imm_src_of(bus.op);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
//==============================================================================
// tb_multicycle_controller: directed instruction sequences with a per-cycle output scoreboard
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_multicycle_controller;

    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [2:0] imm_src;
        logic [1:0] alu_op;
        logic       retire;
        logic       trap;
    } outs_t;

    localparam int T_RST = 0, T_FETCH = 1, T_DECODE = 2, T_MEM_ADR = 3, T_MEM_RD = 4;
    localparam int T_MEM_WB = 5, T_MEM_WR = 6, T_EXEC_R = 7, T_EXEC_I = 8, T_LUI = 9;
    localparam int T_ALU_WB = 10, T_BRANCH = 11, T_JAL = 12, T_JALR = 13, T_JALR_PC = 14;
    localparam int T_ILLEGAL = 15;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    outs_t sb_q[$];
    outs_t got;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign got = {bus.mem_req, bus.MemWrite, bus.AdrSrc, bus.IRWrite, bus.PCWrite,
                  bus.RegWrite, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                  bus.ALUOp, bus.retire, bus.trap};

    function automatic logic [2:0] exp_imm(input logic [6:0] op);
        case (op)
            7'b0000011, 7'b0010011, 7'b1100111: exp_imm = 3'b000;
            7'b0100011: exp_imm = 3'b001;
            7'b1100011: exp_imm = 3'b010;
            7'b1101111: exp_imm = 3'b011;
            7'b0110111: exp_imm = 3'b100;
            default:    exp_imm = 3'b000;
        endcase
    endfunction

    // Expected outputs per state, written straight from the control table.
    function automatic outs_t exp_out(input int st, input logic rdy, input logic taken,
                                      input logic [6:0] op);
        outs_t o;
        o = '0;
        o.imm_src = exp_imm(op);
        case (st)
            T_RST:     begin o.src_b = 2'b10; o.result_src = 2'b10; end
            T_FETCH:   begin o.mem_req = 1'b1; o.src_b = 2'b10; o.result_src = 2'b10;
                             o.ir_write = rdy; o.pc_write = rdy; end
            T_DECODE:  begin o.src_a = 2'b01; o.src_b = 2'b01; end
            T_MEM_ADR: begin o.src_a = 2'b10; o.src_b = 2'b01; end
            T_MEM_RD:  begin o.mem_req = 1'b1; o.adr_src = 1'b1; end
            T_MEM_WB:  begin o.result_src = 2'b01; o.reg_write = 1'b1; o.retire = 1'b1; end
            T_MEM_WR:  begin o.mem_req = 1'b1; o.adr_src = 1'b1; o.mem_write = 1'b1;
                             o.retire = rdy; end
            T_EXEC_R:  begin o.src_a = 2'b10; o.src_b = 2'b00; o.alu_op = 2'b10; end
            T_EXEC_I:  begin o.src_a = 2'b10; o.src_b = 2'b01; o.alu_op = 2'b11; end
            T_LUI:     begin o.src_a = 2'b11; o.src_b = 2'b01; end
            T_ALU_WB:  begin o.reg_write = 1'b1; o.retire = 1'b1; end
            T_BRANCH:  begin o.src_a = 2'b10; o.alu_op = 2'b01; o.pc_write = taken;
                             o.retire = 1'b1; end
            T_JAL, T_JALR_PC: begin o.src_a = 2'b01; o.src_b = 2'b10; o.pc_write = 1'b1; end
            T_JALR:    begin o.src_a = 2'b10; o.src_b = 2'b01; end
            T_ILLEGAL: o.trap = 1'b1;
            default:   o = 'x;
        endcase
        return o;
    endfunction

    task automatic chk(input string tag);
        outs_t e;
        e = sb_q.pop_front();
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, e);
        end
    endtask

    // Called at posedge+1: drive inputs, check at the falling edge, advance.
    task automatic cyc(input string tag, input int st, input logic rdy,
                       input logic z = 1'b0, input logic n = 1'b0, input logic taken = 1'b0);
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.neg       = n;
        sb_q.push_back(exp_out(st, rdy, taken, bus.op));
        @(negedge clk);
        chk(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic now_chk(input string tag, input int st);
        sb_q.push_back(exp_out(st, bus.mem_ready, 1'b0, bus.op));
        chk(tag);
    endtask

    initial begin
        bus.op = 7'b0110011; bus.func3 = 3'b000;
        bus.zero = 1'b0; bus.neg = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        cyc("reset_hold0", T_RST, 1'b1);
        cyc("reset_hold1", T_RST, 1'b1);
        rst = 1'b1;

        // R-type
        cyc("r_fetch",  T_FETCH,  1'b1);
        cyc("r_decode", T_DECODE, 1'b1);
        cyc("r_exec",   T_EXEC_R, 1'b1);
        cyc("r_wb",     T_ALU_WB, 1'b1);

        // load with two memory wait states
        bus.op = 7'b0000011;
        cyc("ld_fetch",  T_FETCH,   1'b1);
        cyc("ld_decode", T_DECODE,  1'b1);
        cyc("ld_adr",    T_MEM_ADR, 1'b1);
        cyc("ld_rd_w0",  T_MEM_RD,  1'b0);
        cyc("ld_rd_w1",  T_MEM_RD,  1'b0);
        cyc("ld_rd_ok",  T_MEM_RD,  1'b1);
        cyc("ld_wb",     T_MEM_WB,  1'b1);

        // beq taken, with one fetch wait state
        bus.op = 7'b1100011; bus.func3 = 3'b000;
        cyc("beq_fetch_w", T_FETCH,  1'b0);
        cyc("beq_fetch",   T_FETCH,  1'b1);
        cyc("beq_decode",  T_DECODE, 1'b1);
        cyc("beq_branch",  T_BRANCH, 1'b1, 1'b1, 1'b0, 1'b1);

        // bge with neg set: not taken
        bus.func3 = 3'b101;
        cyc("bge_fetch",  T_FETCH,  1'b1);
        cyc("bge_decode", T_DECODE, 1'b1);
        cyc("bge_branch", T_BRANCH, 1'b1, 1'b0, 1'b1, 1'b0);

        // bne with zero clear: taken
        bus.func3 = 3'b001;
        cyc("bne_fetch",  T_FETCH,  1'b1);
        cyc("bne_decode", T_DECODE, 1'b1);
        cyc("bne_branch", T_BRANCH, 1'b1, 1'b0, 1'b0, 1'b1);

        // OP-IMM
        bus.op = 7'b0010011; bus.func3 = 3'b000;
        cyc("i_fetch",  T_FETCH,  1'b1);
        cyc("i_decode", T_DECODE, 1'b1);
        cyc("i_exec",   T_EXEC_I, 1'b1);
        cyc("i_wb",     T_ALU_WB, 1'b1);

        // LUI
        bus.op = 7'b0110111;
        cyc("lui_fetch",  T_FETCH,  1'b1);
        cyc("lui_decode", T_DECODE, 1'b1);
        cyc("lui_exec",   T_LUI,    1'b1);
        cyc("lui_wb",     T_ALU_WB, 1'b1);

        // JAL
        bus.op = 7'b1101111;
        cyc("jal_fetch",  T_FETCH,  1'b1);
        cyc("jal_decode", T_DECODE, 1'b1);
        cyc("jal_jump",   T_JAL,    1'b1);
        cyc("jal_wb",     T_ALU_WB, 1'b1);

        // JALR
        bus.op = 7'b1100111;
        cyc("jalr_fetch",  T_FETCH,   1'b1);
        cyc("jalr_decode", T_DECODE,  1'b1);
        cyc("jalr_calc",   T_JALR,    1'b1);
        cyc("jalr_pc",     T_JALR_PC, 1'b1);
        cyc("jalr_wb",     T_ALU_WB,  1'b1);

        // store completing after one wait state
        bus.op = 7'b0100011;
        cyc("st_fetch",  T_FETCH,   1'b1);
        cyc("st_decode", T_DECODE,  1'b1);
        cyc("st_adr",    T_MEM_ADR, 1'b1);
        cyc("st_wr_w0",  T_MEM_WR,  1'b0);
        cyc("st_wr_ok",  T_MEM_WR,  1'b1);

        // store abandoned by reset during a wait state
        cyc("st2_fetch",  T_FETCH,   1'b1);
        cyc("st2_decode", T_DECODE,  1'b1);
        cyc("st2_adr",    T_MEM_ADR, 1'b1);
        cyc("st2_wr_w0",  T_MEM_WR,  1'b0);
        cyc("st2_wr_w1",  T_MEM_WR,  1'b0);
        #2 rst = 1'b0;
        #1 now_chk("st2_async_rst", T_RST);
        @(posedge clk); #1;
        cyc("st2_rst_hold", T_RST, 1'b1);
        rst = 1'b1;
        cyc("st2_restart_fetch",  T_FETCH,   1'b1);
        cyc("st2_restart_decode", T_DECODE,  1'b1);
        cyc("st2_restart_adr",    T_MEM_ADR, 1'b1);
        cyc("st2_restart_wr",     T_MEM_WR,  1'b1);

        // unsupported branch funct3 traps
        bus.op = 7'b1100011; bus.func3 = 3'b010;
        cyc("badbr_fetch",  T_FETCH,   1'b1);
        cyc("badbr_decode", T_DECODE,  1'b1);
        cyc("badbr_trap",   T_ILLEGAL, 1'b1);
        rst = 1'b0;
        #1 now_chk("badbr_async_rst", T_RST);
        @(posedge clk); #1;
        rst = 1'b1;

        // illegal opcode: sticky trap, memory requests ignored
        bus.op = 7'b1111111; bus.func3 = 3'b000;
        cyc("ill_fetch",  T_FETCH,   1'b1);
        cyc("ill_decode", T_DECODE,  1'b1);
        cyc("ill_trap0",  T_ILLEGAL, 1'b1);
        cyc("ill_trap1",  T_ILLEGAL, 1'b1);
        cyc("ill_trap2",  T_ILLEGAL, 1'b0);
        #2 rst = 1'b0;
        #1 now_chk("ill_async_rst", T_RST);
        @(posedge clk); #1;
        rst = 1'b1;
        bus.op = 7'b0110011;
        cyc("post_fetch",  T_FETCH,  1'b1);
        cyc("post_decode", T_DECODE, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
